// File: rtl/merge_pkg.sv
// Shared types and defaults for the merge output FIFO.
// Handshake FSM state encodings live here so the bench and RTL agree.
package merge_pkg;

    localparam int MERGE_WIDTH_DEFAULT = 8;
    localparam int MERGE_DEPTH_DEFAULT = 4;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_t;

endpackage

// File: rtl/merge_out_fifo_if.sv
// 4-phase bundled-data handshake bundle for merge_out_fifo.
// master drives upstream request and downstream acknowledge.
interface merge_out_fifo_if
    import merge_pkg::*;
#(
    parameter int WIDTH = MERGE_WIDTH_DEFAULT,
    parameter int DEPTH = MERGE_DEPTH_DEFAULT
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_req;
    logic [WIDTH-1:0] in_data;
    logic             in_ack;
    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;
    logic [CW-1:0]    count;

    modport master (
        output in_req,
        output in_data,
        output out_ack,
        input  in_ack,
        input  out_req,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_req,
        input  in_data,
        input  out_ack,
        output in_ack,
        output out_req,
        output out_data,
        output count
    );

endinterface

// File: rtl/merge_out_fifo_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Async active-high reset clears both stages.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/merge_out_fifo.sv
// 4-phase in / 4-phase out FIFO behind a merge element.
// Define MERGE_OUT_FIFO_SYNC_EN to synchronise in_req and out_ack.
module merge_out_fifo
    import merge_pkg::*;
#(
    parameter int WIDTH = MERGE_WIDTH_DEFAULT,
    parameter int DEPTH = MERGE_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    merge_out_fifo_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic in_req_s;
    logic out_ack_s;

`ifdef MERGE_OUT_FIFO_SYNC_EN
    sync2 u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (bus.in_req),
        .q   (in_req_s)
    );

    sync2 u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (bus.out_ack),
        .q   (out_ack_s)
    );
`else
    assign in_req_s  = bus.in_req;
    assign out_ack_s = bus.out_ack;
`endif

    in_state_t        in_state;
    out_state_t       out_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] data_q;
    logic             full;
    logic             push;
    logic             pop;

    // Occupancy alone decides full/empty; pointers are equal in both.
    assign full = (cnt == CW'(DEPTH));
    assign push = (in_state == IN_IDLE) && in_req_s && !full;
    assign pop  = (out_state == OUT_REQ) && out_ack_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state <= IN_IDLE;
        end else begin
            unique case (in_state)
                IN_IDLE: if (push)      in_state <= IN_ACK;
                IN_ACK:  if (!in_req_s) in_state <= IN_IDLE;
                default:                in_state <= IN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state <= OUT_IDLE;
            data_q    <= '0;
        end else begin
            unique case (out_state)
                OUT_IDLE: begin
                    if (cnt != '0) begin
                        data_q    <= mem[rptr];
                        out_state <= OUT_REQ;
                    end
                end
                OUT_REQ:  if (out_ack_s)  out_state <= OUT_WAIT;
                OUT_WAIT: if (!out_ack_s) out_state <= OUT_IDLE;
                default:                  out_state <= OUT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    assign bus.in_ack   = (in_state == IN_ACK);
    assign bus.out_req  = (out_state == OUT_REQ);
    assign bus.out_data = data_q;
    assign bus.count    = cnt;

endmodule
